// File: rtl/rssi_cfg_pkg.sv
// Shared constants and state encoding for the RSSI reconfiguration controller.
package rssi_cfg_pkg;

    localparam int unsigned DEF_DELAY_CTL_WIDTH    = 7;
    localparam int unsigned DEF_RSSI_HALF_DB_WIDTH = 11;
    localparam int unsigned DEF_RST_HOLD_CYCLES    = 4;
    localparam int unsigned DEF_TIMEOUT_WIDTH      = 16;

    // Extra samples beyond delay_ctl before the delay line output is trusted.
    localparam int unsigned REFILL_MARGIN = 2;

    localparam int unsigned STATE_WIDTH = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        STABLE    = 2'd0,
        WAIT_IDLE = 2'd1,
        FLUSH     = 2'd2,
        REFILL    = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/rssi_cfg_ctl_if.sv
// Register-bank side of the RSSI reconfiguration controller: request fields and status readback.
interface rssi_cfg_ctl_if
    import rssi_cfg_pkg::*;
#(
    parameter int unsigned DELAY_CTL_WIDTH    = DEF_DELAY_CTL_WIDTH,
    parameter int unsigned RSSI_HALF_DB_WIDTH = DEF_RSSI_HALF_DB_WIDTH,
    parameter int unsigned TIMEOUT_WIDTH      = DEF_TIMEOUT_WIDTH
);

    logic [DELAY_CTL_WIDTH-1:0]    cfg_delay_ctl;
    logic [RSSI_HALF_DB_WIDTH-1:0] cfg_offset;
    logic                          cfg_update;
    logic [TIMEOUT_WIDTH-1:0]      idle_timeout;
    logic                          cfg_pending;
    logic                          cfg_done;
    logic                          cfg_forced;
    logic [STATE_WIDTH-1:0]        state;

    modport master (
        output cfg_delay_ctl, cfg_offset, cfg_update, idle_timeout,
        input  cfg_pending, cfg_done, cfg_forced, state
    );

    modport slave (
        input  cfg_delay_ctl, cfg_offset, cfg_update, idle_timeout,
        output cfg_pending, cfg_done, cfg_forced, state
    );

endinterface

// File: rtl/rssi_cfg_ctl.sv
// Sequences delay_ctl / offset changes into the rssi block: wait for rx idle, flush the delay FIFO, refill.
// Optional forced-flush timeout in WAIT_IDLE is compiled in with RSSI_CFG_CTL_TIMEOUT_EN.
module rssi_cfg_ctl
    import rssi_cfg_pkg::*;
#(
    parameter int unsigned DELAY_CTL_WIDTH    = DEF_DELAY_CTL_WIDTH,
    parameter int unsigned RSSI_HALF_DB_WIDTH = DEF_RSSI_HALF_DB_WIDTH,
    parameter int unsigned RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
    parameter int unsigned TIMEOUT_WIDTH      = DEF_TIMEOUT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rstn,
    rssi_cfg_ctl_if.slave                 cfg,
    input  logic                          rx_busy,
    input  logic                          sample_tick,
    output logic [DELAY_CTL_WIDTH-1:0]    delay_ctl,
    output logic [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db_offset,
    output logic                          fifo_delay_rstn,
    output logic                          rssi_stable
);

    localparam int unsigned CNT_WIDTH  = DELAY_CTL_WIDTH + 1;
    localparam int unsigned HOLD_WIDTH = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD = HOLD_WIDTH'(RST_HOLD_CYCLES - 1);

    cfg_state_e state_q, state_d;

    logic [DELAY_CTL_WIDTH-1:0]    shadow_delay_q, shadow_delay_d;
    logic [RSSI_HALF_DB_WIDTH-1:0] shadow_offset_q, shadow_offset_d;
    logic [DELAY_CTL_WIDTH-1:0]    delay_q, delay_d;
    logic [RSSI_HALF_DB_WIDTH-1:0] offset_q, offset_d;
    logic                          pending_q, pending_d;
    logic                          fifo_rstn_q, fifo_rstn_d;
    logic                          stable_q, stable_d;
    logic                          done_q, done_d;
    logic                          forced_q, forced_d;
    logic                          init_q, init_d;
    logic [HOLD_WIDTH-1:0]         hold_q, hold_d;
    logic [CNT_WIDTH-1:0]          refill_q, refill_d;

    logic [CNT_WIDTH-1:0] refill_target;
    logic [CNT_WIDTH-1:0] refill_next;
    logic                 refill_hit;
    logic                 keep_pending;
    logic                 tmo_hit;
    logic                 flush_go;

    // Target is one bit wider than delay_ctl so the all-ones delay does not wrap.
    assign refill_target = CNT_WIDTH'(delay_q) + CNT_WIDTH'(REFILL_MARGIN);
    assign refill_next   = refill_q + CNT_WIDTH'(1);
    assign refill_hit    = sample_tick && (refill_next == refill_target);
    assign keep_pending  = pending_q || cfg.cfg_update;
    assign flush_go      = !rx_busy || tmo_hit;

`ifdef RSSI_CFG_CTL_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tmo_q;

    // Busy-cycle counter, restarted on every WAIT_IDLE entry.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmo_q <= '0;
        end else if (state_q != WAIT_IDLE) begin
            tmo_q <= '0;
        end else if (rx_busy) begin
            tmo_q <= tmo_q + TIMEOUT_WIDTH'(1);
        end
    end

    assign tmo_hit = rx_busy && (cfg.idle_timeout != '0) && (tmo_q == cfg.idle_timeout);
`else
    logic unused_idle_timeout;

    assign tmo_hit             = 1'b0;
    assign unused_idle_timeout = ^cfg.idle_timeout;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= STABLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the first cycle after reset runs an initial refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STABLE: begin
                if (init_q) begin
                    state_d = REFILL;
                end else if (pending_q) begin
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (flush_go) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (hold_q == '0) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (refill_hit) begin
                    state_d = keep_pending ? WAIT_IDLE : STABLE;
                end
            end
            default: state_d = STABLE;
        endcase
    end

    // Next values of the registered outputs, shadows and counters.
    always_comb begin
        shadow_delay_d  = shadow_delay_q;
        shadow_offset_d = shadow_offset_q;
        delay_d         = delay_q;
        offset_d        = offset_q;
        pending_d       = pending_q;
        fifo_rstn_d     = 1'b1;
        stable_d        = stable_q;
        done_d          = 1'b0;
        forced_d        = forced_q;
        init_d          = init_q;
        hold_d          = hold_q;
        refill_d        = refill_q;

        if (cfg.cfg_update) begin
            shadow_delay_d  = cfg.cfg_delay_ctl;
            shadow_offset_d = cfg.cfg_offset;
            pending_d       = 1'b1;
            forced_d        = 1'b0;
        end

        case (state_q)
            STABLE: begin
                if (init_q) begin
                    refill_d = '0;
                end
            end
            WAIT_IDLE: begin
                // Apply the pre-strobe shadows; a same-cycle strobe stays pending.
                if (flush_go) begin
                    delay_d     = shadow_delay_q;
                    offset_d    = shadow_offset_q;
                    pending_d   = cfg.cfg_update;
                    fifo_rstn_d = 1'b0;
                    stable_d    = 1'b0;
                    hold_d      = HOLD_LOAD;
                    if (tmo_hit) begin
                        forced_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (hold_q == '0) begin
                    refill_d = '0;
                end else begin
                    hold_d      = hold_q - HOLD_WIDTH'(1);
                    fifo_rstn_d = 1'b0;
                end
            end
            REFILL: begin
                if (sample_tick) begin
                    refill_d = refill_next;
                end
                if (refill_hit) begin
                    init_d = 1'b0;
                    if (!keep_pending) begin
                        stable_d = 1'b1;
                        done_d   = !init_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shadow_delay_q  <= '0;
            shadow_offset_q <= '0;
            delay_q         <= '0;
            offset_q        <= '0;
            pending_q       <= 1'b0;
            fifo_rstn_q     <= 1'b0;
            stable_q        <= 1'b0;
            done_q          <= 1'b0;
            forced_q        <= 1'b0;
            init_q          <= 1'b1;
            hold_q          <= '0;
            refill_q        <= '0;
        end else begin
            shadow_delay_q  <= shadow_delay_d;
            shadow_offset_q <= shadow_offset_d;
            delay_q         <= delay_d;
            offset_q        <= offset_d;
            pending_q       <= pending_d;
            fifo_rstn_q     <= fifo_rstn_d;
            stable_q        <= stable_d;
            done_q          <= done_d;
            forced_q        <= forced_d;
            init_q          <= init_d;
            hold_q          <= hold_d;
            refill_q        <= refill_d;
        end
    end

    assign delay_ctl           = delay_q;
    assign rssi_half_db_offset = offset_q;
    assign fifo_delay_rstn     = fifo_rstn_q;
    assign rssi_stable         = stable_q;
    assign cfg.cfg_pending     = pending_q;
    assign cfg.cfg_done        = done_q;
    assign cfg.cfg_forced      = forced_q;
    assign cfg.state           = state_q;

endmodule

// File: tb/tb_rssi_cfg_ctl.sv
// Randomized self-checking bench for rssi_cfg_ctl against a cycle-count model of the update sequence.
// Also covers RSSI_CFG_CTL_TIMEOUT_EN when that macro is defined for the build.
module tb_rssi_cfg_ctl;

    localparam int DW = 7;
    localparam int OW = 11;
    localparam int H  = 4;

    localparam logic [1:0] S_STABLE = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_REFILL = 2'd3;

    logic          clk;
    logic          rstn;
    logic          rx_busy;
    logic          sample_tick;
    logic [DW-1:0] delay_ctl;
    logic [OW-1:0] rssi_half_db_offset;
    logic          fifo_delay_rstn;
    logic          rssi_stable;

    rssi_cfg_ctl_if cfg_if ();

    rssi_cfg_ctl #(
        .DELAY_CTL_WIDTH   (DW),
        .RSSI_HALF_DB_WIDTH(OW),
        .RST_HOLD_CYCLES   (H),
        .TIMEOUT_WIDTH     (16)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .cfg                (cfg_if),
        .rx_busy            (rx_busy),
        .sample_tick        (sample_tick),
        .delay_ctl          (delay_ctl),
        .rssi_half_db_offset(rssi_half_db_offset),
        .fifo_delay_rstn    (fifo_delay_rstn),
        .rssi_stable        (rssi_stable)
    );

    int n_cmp = 0;
    int n_err = 0;
    int fifo_low_total = 0;
    int done_total = 0;

    // Reference: applied settings and the latched (shadow) request.
    logic [DW-1:0] model_delay;
    logic [OW-1:0] model_offset;
    logic [DW-1:0] sh_delay;
    logic [OW-1:0] sh_offset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn) begin
            if (!fifo_delay_rstn) fifo_low_total <= fifo_low_total + 1;
            if (cfg_if.cfg_done)  done_total     <= done_total + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step();
            sample_tick = 1'b1;
            step();
            sample_tick = 1'b0;
        end
    endtask

    task automatic strobe(input int d, input int o);
        cfg_if.cfg_delay_ctl = DW'(d);
        cfg_if.cfg_offset    = OW'(o);
        cfg_if.cfg_update    = 1'b1;
        step();
        cfg_if.cfg_update    = 1'b0;
        sh_delay  = DW'(d);
        sh_offset = OW'(o);
        n_cmp++;
        if (cfg_if.cfg_pending !== 1'b1) begin
            n_err++;
            $display("FAIL strobe_pending: got %0b want 1", cfg_if.cfg_pending);
        end
    endtask

    // Runs until FLUSH, checks the applied values and the FIFO reset width, stops at REFILL entry.
    task automatic wait_flush(input logic exp_stable, output int waited);
        int bad;
        int fl;
        int low0;
        bad = 0;
        waited = 0;
        while (cfg_if.state !== S_FLUSH && waited < 2000) begin
            if (delay_ctl !== model_delay || rssi_stable !== exp_stable || fifo_delay_rstn !== 1'b1) bad++;
            step();
            waited++;
        end
        n_cmp++;
        if (cfg_if.state !== S_FLUSH) begin
            n_err++;
            $display("FAIL flush_reach: got state %0d want %0d", cfg_if.state, S_FLUSH);
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL wait_hold: got %0d bad cycles want 0", bad);
        end
        model_delay  = sh_delay;
        model_offset = sh_offset;
        n_cmp++;
        if ({delay_ctl, rssi_half_db_offset, fifo_delay_rstn, rssi_stable, cfg_if.cfg_pending}
            !== {model_delay, model_offset, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL flush_entry: got delay %0d off %0d fifo %0b stable %0b pend %0b want delay %0d off %0d fifo 0 stable 0 pend 0",
                     delay_ctl, rssi_half_db_offset, fifo_delay_rstn, rssi_stable, cfg_if.cfg_pending,
                     model_delay, model_offset);
        end
        low0 = fifo_low_total;
        fl = 0;
        while (cfg_if.state !== S_REFILL && fl < 100) begin
            sample_tick = 1'($urandom_range(0, 1));
            rx_busy     = 1'($urandom_range(0, 1));
            step();
            fl++;
        end
        sample_tick = 1'b0;
        rx_busy     = 1'b0;
        n_cmp++;
        if (fifo_low_total - low0 != H || fifo_delay_rstn !== 1'b1 || cfg_if.state !== S_REFILL) begin
            n_err++;
            $display("FAIL flush_width: got %0d low cycles (fifo %0b state %0d) want %0d low then fifo 1 state 3",
                     fifo_low_total - low0, fifo_delay_rstn, cfg_if.state, H);
        end
    endtask

    task automatic run_refill(input int n, input logic exp_done);
        int bad;
        int db;
        bad = 0;
        db = done_total;
        n_cmp++;
        if (cfg_if.state !== S_REFILL) begin
            n_err++;
            $display("FAIL refill_entry: got state %0d want %0d", cfg_if.state, S_REFILL);
        end
        for (int i = 1; i <= n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                if (cfg_if.state !== S_REFILL || rssi_stable !== 1'b0) bad++;
                step();
            end
            sample_tick = 1'b1;
            step();
            sample_tick = 1'b0;
            if (i < n && (cfg_if.state !== S_REFILL || rssi_stable !== 1'b0)) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL refill_early: got %0d bad cycles want 0 (target %0d)", bad, n);
        end
        n_cmp++;
        if ({cfg_if.state, rssi_stable, cfg_if.cfg_done} !== {S_STABLE, 1'b1, exp_done}) begin
            n_err++;
            $display("FAIL refill_end: got state %0d stable %0b done %0b want state 0 stable 1 done %0b",
                     cfg_if.state, rssi_stable, cfg_if.cfg_done, exp_done);
        end
        step();
        n_cmp++;
        if (cfg_if.cfg_done !== 1'b0 || done_total != db + int'(exp_done)) begin
            n_err++;
            $display("FAIL done_pulse: got done %0b count %0d want done 0 count %0d",
                     cfg_if.cfg_done, done_total - db, int'(exp_done));
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rx_busy = 1'b0;
        sample_tick = 1'b0;
        cfg_if.cfg_update = 1'b0;
        cfg_if.cfg_delay_ctl = '0;
        cfg_if.cfg_offset = '0;
        cfg_if.idle_timeout = '0;
        model_delay = '0; model_offset = '0; sh_delay = '0; sh_offset = '0;
        repeat (3) step();
        n_cmp++;
        if ({cfg_if.state, delay_ctl, rssi_half_db_offset, fifo_delay_rstn, rssi_stable,
             cfg_if.cfg_pending, cfg_if.cfg_done, cfg_if.cfg_forced} !== 25'd0) begin
            n_err++;
            $display("FAIL reset_values: got state %0d delay %0d off %0d fifo %0b stable %0b pend %0b done %0b forced %0b want all 0",
                     cfg_if.state, delay_ctl, rssi_half_db_offset, fifo_delay_rstn, rssi_stable,
                     cfg_if.cfg_pending, cfg_if.cfg_done, cfg_if.cfg_forced);
        end
        rstn = 1'b1;
        step();
        n_cmp++;
        if ({cfg_if.state, fifo_delay_rstn, rssi_stable} !== {S_REFILL, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_release: got state %0d fifo %0b stable %0b want state 3 fifo 1 stable 0",
                     cfg_if.state, fifo_delay_rstn, rssi_stable);
        end
        run_refill(2, 1'b0);
        n_cmp++;
        if ({delay_ctl, rssi_half_db_offset} !== '0) begin
            n_err++;
            $display("FAIL init_settings: got delay %0d off %0d want 0 0", delay_ctl, rssi_half_db_offset);
        end
    endtask

    task automatic test_basic();
        int w;
        strobe(10, 300);
        wait_flush(1'b1, w);
        n_cmp++;
        if (w != 2) begin
            n_err++;
            $display("FAIL basic_latency: got %0d want 2", w);
        end
        run_refill(int'(model_delay) + 2, 1'b1);
    endtask

    task automatic test_busy_wait();
        int w;
        int bad;
        bad = 0;
        rx_busy = 1'b1;
        repeat (500) step();
        strobe($urandom_range(0, 127), $urandom_range(0, 2047));
        repeat ($urandom_range(20, 60)) begin
            if (delay_ctl !== model_delay || rssi_stable !== 1'b1 || fifo_delay_rstn !== 1'b1) bad++;
            step();
        end
        n_cmp++;
        if (cfg_if.state !== S_WAIT || bad != 0) begin
            n_err++;
            $display("FAIL busy_hold: got state %0d bad %0d want state 1 bad 0", cfg_if.state, bad);
        end
        rx_busy = 1'b0;
        wait_flush(1'b1, w);
        n_cmp++;
        if (w != 1) begin
            n_err++;
            $display("FAIL busy_release: got %0d want 1", w);
        end
        run_refill(int'(model_delay) + 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        int w;
        int k;
        strobe(10, $urandom_range(0, 2047));
        wait_flush(1'b1, w);
        k = $urandom_range(1, 10);
        send_ticks(k);
        strobe(20, $urandom_range(0, 2047));
        send_ticks(12 - k - 1);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        n_cmp++;
        if ({cfg_if.state, cfg_if.cfg_done, rssi_stable, cfg_if.cfg_pending} !== {S_WAIT, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_redirect: got state %0d done %0b stable %0b pend %0b want 1 0 0 1",
                     cfg_if.state, cfg_if.cfg_done, rssi_stable, cfg_if.cfg_pending);
        end
        wait_flush(1'b0, w);
        n_cmp++;
        if (w != 1 || delay_ctl !== DW'(20)) begin
            n_err++;
            $display("FAIL b2b_reflush: got wait %0d delay %0d want 1 20", w, delay_ctl);
        end
        run_refill(22, 1'b1);
    endtask

    task automatic test_same_cycle();
        int w;
        int d2;
        int o2;
        strobe($urandom_range(0, 15), $urandom_range(0, 2047));
        wait_flush(1'b1, w);
        send_ticks(int'(model_delay) + 1);
        d2 = $urandom_range(0, 127);
        o2 = $urandom_range(0, 2047);
        cfg_if.cfg_delay_ctl = DW'(d2);
        cfg_if.cfg_offset    = OW'(o2);
        cfg_if.cfg_update    = 1'b1;
        sample_tick          = 1'b1;
        step();
        cfg_if.cfg_update = 1'b0;
        sample_tick       = 1'b0;
        sh_delay  = DW'(d2);
        sh_offset = OW'(o2);
        n_cmp++;
        if ({cfg_if.state, cfg_if.cfg_done, cfg_if.cfg_pending, rssi_stable} !== {S_WAIT, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL same_cycle: got state %0d done %0b pend %0b stable %0b want 1 0 1 0",
                     cfg_if.state, cfg_if.cfg_done, cfg_if.cfg_pending, rssi_stable);
        end
        wait_flush(1'b0, w);
        run_refill(d2 + 2, 1'b1);
    endtask

    task automatic test_timeout();
        int w;
        int bad;
        bad = 0;
        cfg_if.idle_timeout = 16'd100;
        rx_busy = 1'b1;
        strobe($urandom_range(0, 127), $urandom_range(0, 2047));
        step();
`ifdef RSSI_CFG_CTL_TIMEOUT_EN
        wait_flush(1'b1, w);
        n_cmp++;
        if (w != 101 || cfg_if.cfg_forced !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_flush: got wait %0d forced %0b want 101 1", w, cfg_if.cfg_forced);
        end
        run_refill(int'(model_delay) + 2, 1'b1);
        cfg_if.idle_timeout = '0;
        strobe($urandom_range(0, 127), $urandom_range(0, 2047));
        n_cmp++;
        if (cfg_if.cfg_forced !== 1'b0) begin
            n_err++;
            $display("FAIL forced_clear: got %0b want 0", cfg_if.cfg_forced);
        end
        wait_flush(1'b1, w);
`else
        repeat (300) begin
            if (cfg_if.state !== S_WAIT || cfg_if.cfg_forced !== 1'b0) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL no_timeout: got %0d bad cycles want 0", bad);
        end
        cfg_if.idle_timeout = '0;
        rx_busy = 1'b0;
        wait_flush(1'b1, w);
`endif
        run_refill(int'(model_delay) + 2, 1'b1);
    endtask

    task automatic test_random();
        int w;
        logic busy;
        for (int it = 0; it < 6; it++) begin
            busy = 1'($urandom_range(0, 1));
            rx_busy = busy;
            strobe($urandom_range(0, 127), $urandom_range(0, 2047));
            if (busy) begin
                repeat ($urandom_range(1, 30)) step();
                rx_busy = 1'b0;
            end
            wait_flush(1'b1, w);
            n_cmp++;
            if (w != (busy ? 1 : 2)) begin
                n_err++;
                $display("FAIL rand_latency: got %0d want %0d", w, busy ? 1 : 2);
            end
            run_refill(int'(model_delay) + 2, 1'b1);
        end
    endtask

    task automatic test_max_delay_reset();
        int w;
        int bad;
        bad = 0;
        strobe(127, $urandom_range(0, 2047));
        wait_flush(1'b1, w);
        send_ticks(128);
        n_cmp++;
        if (cfg_if.state !== S_REFILL || rssi_stable !== 1'b0) begin
            n_err++;
            $display("FAIL max_no_wrap: got state %0d stable %0b want 3 0", cfg_if.state, rssi_stable);
        end
        run_refill(1, 1'b1);
        strobe(55, $urandom_range(0, 2047));
        wait_flush(1'b1, w);
        send_ticks($urandom_range(3, 20));
        strobe(9, $urandom_range(0, 2047));
        rstn = 1'b0;
        step();
        model_delay = '0; model_offset = '0; sh_delay = '0; sh_offset = '0;
        n_cmp++;
        if ({cfg_if.state, delay_ctl, rssi_half_db_offset, fifo_delay_rstn, rssi_stable,
             cfg_if.cfg_pending, cfg_if.cfg_done, cfg_if.cfg_forced} !== 25'd0) begin
            n_err++;
            $display("FAIL mid_reset: got state %0d delay %0d off %0d fifo %0b stable %0b pend %0b done %0b forced %0b want all 0",
                     cfg_if.state, delay_ctl, rssi_half_db_offset, fifo_delay_rstn, rssi_stable,
                     cfg_if.cfg_pending, cfg_if.cfg_done, cfg_if.cfg_forced);
        end
        rstn = 1'b1;
        step();
        run_refill(2, 1'b0);
        repeat (20) begin
            if (cfg_if.state !== S_STABLE || cfg_if.cfg_pending !== 1'b0) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL stale_request: got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_wait();
        test_back_to_back();
        test_same_cycle();
        test_timeout();
        test_random();
        test_max_delay_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rssi_cfg_ctl.md
Name: rssi_cfg_ctl

Overview:
- Sequences run-time reconfiguration of the RSSI datapath: the gpio_status delay line length (delay_ctl) and the dB offset (rssi_half_db_offset).
- Latches software requests, waits until no packet reception is ongoing, then flushes the delay FIFO via fifo_delay_rstn. It applies the new settings and holds rssi_stable low until the delay line has refilled.
- Sits between the xpu register bank and the rssi block. Its outputs drive rssi's delay_ctl, rssi_half_db_offset and fifo_delay_rstn inputs directly.

Parameters:
- DELAY_CTL_WIDTH, 7, width of delay_ctl.
- RSSI_HALF_DB_WIDTH, 11, width of the offset.
- RST_HOLD_CYCLES, 4, number of clk cycles fifo_delay_rstn is held low during a flush (minimum 1).
- TIMEOUT_WIDTH, 16, width of the idle-wait timeout counter.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- cfg_delay_ctl  in  DELAY_CTL_WIDTH  requested delay.
- cfg_offset  in  RSSI_HALF_DB_WIDTH  requested offset (half dB).
- cfg_update  in  1  single-cycle strobe; samples cfg_delay_ctl and cfg_offset.
- rx_busy  in  1  high while packet reception is ongoing; a flush is not permitted while it is high.
- sample_tick  in  1  connects to iq_rssi_half_db_valid; counts refill samples.
- idle_timeout  in  TIMEOUT_WIDTH  forced-update limit; used only when the optional feature is compiled in.
- delay_ctl  out  DELAY_CTL_WIDTH  applied delay.
- rssi_half_db_offset  out  RSSI_HALF_DB_WIDTH  applied offset.
- fifo_delay_rstn  out  1  active-low flush of the delay FIFO.
- rssi_stable  out  1  high when rssi_half_db reflects the current settings.
- cfg_pending  out  1  a request has been latched but not yet applied.
- cfg_done  out  1  one-cycle pulse when the sequence completes.
- cfg_forced  out  1  sticky flag: the last update was applied by timeout; cleared by the next cfg_update.
- state  out  2  current FSM state, for debug/register readback.

Behaviour:
- Reset values (rstn=0 at a clk edge):
  - State STABLE.
  - delay_ctl=0, rssi_half_db_offset=0.
  - fifo_delay_rstn=0 during reset; it goes to 1 on the first clk edge after rstn=1.
  - rssi_stable=0 until the initial refill completes: after reset the block enters REFILL with the target count computed from delay_ctl=0.
  - cfg_pending=0, cfg_done=0, cfg_forced=0. Shadow registers = 0.
- Reset mid-operation aborts any sequence and discards the shadow registers and pending request.
- State encoding: STABLE=0, WAIT_IDLE=1, FLUSH=2, REFILL=3.
- cfg_update in any state:
  - On the next edge, shadow registers take cfg_delay_ctl and cfg_offset, and cfg_pending=1.
  - A later strobe overwrites the shadows (last request wins).
- STABLE: if cfg_pending=1, go to WAIT_IDLE. rssi_stable=1.
- WAIT_IDLE:
  - Old settings remain applied; rssi_stable stays 1.
  - When rx_busy=0 in a cycle, on that edge copy shadows to delay_ctl and rssi_half_db_offset, clear cfg_pending, drive fifo_delay_rstn=0 and rssi_stable=0, load the hold counter, and go to FLUSH.
- FLUSH:
  - fifo_delay_rstn stays 0 for exactly RST_HOLD_CYCLES cycles. rx_busy is ignored here.
  - Then fifo_delay_rstn=1, the refill counter clears, and the FSM goes to REFILL.
- REFILL:
  - Counts sample_tick pulses. The target is delay_ctl+2, computed at DELAY_CTL_WIDTH+1 bits so no wrap at the all-ones value.
  - On the edge where the count reaches the target:
    - If cfg_pending=0: go to STABLE, rssi_stable=1, cfg_done pulses for one cycle.
    - If cfg_pending=1: go directly to WAIT_IDLE with no cfg_done pulse and rssi_stable still 0.
- cfg_update in the same cycle as refill completion: the pending path is taken and cfg_done does not pulse.
- sample_tick in FLUSH is ignored.
- Latency: with rx_busy=0 and no ticks outstanding, a cfg_update strobe at cycle 0 gives FLUSH at cycle 3 and fifo_delay_rstn low during cycles 3 to 3+RST_HOLD_CYCLES-1. The FSM enters REFILL one edge after the last low cycle; cfg_done then pulses one cycle after the (delay_ctl+2)-th tick.

Optional Feature:
- Macro RSSI_CFG_CTL_TIMEOUT_EN.
- Defined:
  - A counter clears on WAIT_IDLE entry and increments each cycle while in WAIT_IDLE with rx_busy=1.
  - When it equals idle_timeout (nonzero), the flush proceeds despite rx_busy and cfg_forced is set.
  - idle_timeout=0 disables the timeout.
- Not defined: WAIT_IDLE waits indefinitely, idle_timeout is unused, and cfg_forced is tied to 0.

Decomposition:
- Package rssi_cfg_pkg holds:
  - the state encoding constants (STABLE, WAIT_IDLE, FLUSH, REFILL);
  - the default widths;
  - the refill margin constant 2.
- No sub-module: counters and the FSM stay in one module.

Test Plan:
- Post-reset, 2 sample_ticks with no cfg_update -> rssi_stable rises after the 2nd tick; delay_ctl=0, offset=0, no cfg_done.
- cfg_update with delay 10 and offset 300, rx_busy=0 -> fifo_delay_rstn low exactly 4 cycles, offset=300 at FLUSH entry, cfg_done one cycle after the 12th tick.
- rx_busy=1 for 500 cycles, then cfg_update, then rx_busy falls -> FLUSH starts the edge after rx_busy=0; old delay and rssi_stable=1 held throughout.
- Second cfg_update (delay 20) during REFILL of the first -> no cfg_done after the first refill; returns to WAIT_IDLE, reflushes, and cfg_done pulses once with delay_ctl=20.
- delay 127 -> refill target 129 ticks, no wrap; rstn=0 in mid-REFILL -> all outputs take reset values and no pending request remains.
- With RSSI_CFG_CTL_TIMEOUT_EN, idle_timeout=100, rx_busy held 1 -> flush after 100 cycles in WAIT_IDLE and cfg_forced=1. Without the macro -> stays in WAIT_IDLE indefinitely.
